// File: rtl/fetch_pipe_adder_pkg.sv
// Shared definitions for the fetch-unit pipelined adder: stage count derivation,
// segment-width legality check and the per-stage control record.
package fetch_pipe_adder_pkg;

    // Control half of a pipeline stage record; the data half depends on WIDTH
    // and is declared alongside it in fetch_pipe_adder.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int unsigned stages_of(input int unsigned width, input int unsigned seg);
        if (seg == 0 || width < seg) begin
            return 1;
        end
        return width / seg;
    endfunction

    function automatic bit seg_fits(input int unsigned width, input int unsigned seg);
        return (seg != 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/fetch_adder_seg.sv
// Combinational SEG-bit adder slice with carry-in and carry-out; one per pipeline stage.
module fetch_adder_seg #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);
    logic [SEG:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
        sum   = total[SEG-1:0];
        cout  = total[SEG];
    end

endmodule

// File: rtl/fetch_pipe_adder.sv
// Pipelined carry-segmented adder: one SEG-bit segment resolved per stage, valid/ready
// on both sides. Define FETCH_PIPE_ADDER_OVF_EN to build the signed-overflow output.
module fetch_pipe_adder
    import fetch_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int unsigned STAGES = stages_of(WIDTH, SEG);

    if (!seg_fits(WIDTH, SEG)) begin : g_bad_seg
        $error("fetch_pipe_adder: WIDTH must be a nonzero multiple of SEG");
    end

    // sum holds the segments resolved so far; a/b still carry the pending upper segments.
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t         st_q     [STAGES];
    stage_t         src      [STAGES];
    stage_t         nxt      [STAGES];
    logic [SEG-1:0] seg_sum  [STAGES];
    logic           seg_cout [STAGES];
    logic           adv;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = st_q[STAGES-1].ctl.valid;
    assign out_sum   = st_q[STAGES-1].sum;
    assign out_cout  = st_q[STAGES-1].ctl.carry;

    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (i == 0) begin
                src[i].ctl.valid = in_valid;
                src[i].ctl.carry = in_cin;
                src[i].sum       = '0;
                src[i].a         = in_a;
                src[i].b         = in_b;
            end else begin
                src[i] = st_q[i-1];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        fetch_adder_seg #(
            .SEG(SEG)
        ) u_seg (
            .a    (src[g].a[g*SEG +: SEG]),
            .b    (src[g].b[g*SEG +: SEG]),
            .cin  (src[g].ctl.carry),
            .sum  (seg_sum[g]),
            .cout (seg_cout[g])
        );
    end

    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            nxt[i]                   = src[i];
            nxt[i].ctl.carry         = seg_cout[i];
            nxt[i].sum[i*SEG +: SEG] = seg_sum[i];
        end
    end

    // A stall freezes every stage, bubbles included, so order and spacing are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                st_q[i] <= '0;
            end
        end else if (adv) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                st_q[i] <= nxt[i];
            end
        end
    end

`ifdef FETCH_PIPE_ADDER_OVF_EN
    logic sign_a_q;
    logic sign_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else if (adv) begin
            sign_a_q <= src[STAGES-1].a[WIDTH-1];
            sign_b_q <= src[STAGES-1].b[WIDTH-1];
        end
    end

    assign out_ovf = out_valid & (sign_a_q == sign_b_q) & (out_sum[WIDTH-1] != sign_a_q);
`else
    assign out_ovf = 1'b0;
`endif

endmodule
